dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
// - Shares the single-port data RAM (dram) between the CPU load/store path and a host/debug loader.
// - CPU has default priority.
// - Host issues bursts of 1..2^BURST_W words.
// - A starvation counter forces one host beat after MAX_WAIT denied cycles.
// - During that forced beat the CPU is stalled: the PC holds and the register write is suppressed.
// - Sits between the core (aluout/data/wmem) and dram; drives the stall that gates pcreg.
// PARAMETERS
// ADDR_W   10  word-address width into dram
// DATA_W   32  data width
// BURST_W  4   host burst-length field width (beats = host_len+1)
// MAX_WAIT 8   consecutive denied host cycles before host is forced through (>=1)
// PORTS
// clock        in   1        single system clock, all state on rising edge
// reset        in   1        synchronous, active-high
// cpu_req      in   1        core needs dram this cycle (load or store)
// cpu_we       in   1        core store (wmem)
// cpu_addr     in   ADDR_W   core word address (aluout[9:0])
// cpu_wdata    in   DATA_W   core store data
// cpu_rdata    out  DATA_W   load data to core, combinational from mem_rdata
// cpu_stall    out  1        core access denied this cycle; core must hold PC and suppress writeback
// host_req     in   1        host burst request, sampled only in IDLE
// host_we      in   1        burst direction (1 = write), latched at start
// host_addr    in   ADDR_W   burst base address, latched at start
// host_len     in   BURST_W  beats-1, latched at start
// host_wdata   in   DATA_W   current beat write data; host advances it after host_gnt
// host_gnt     out  1        combinational: host beat performed this cycle
// host_rdata   out  DATA_W   registered read data
// host_rvalid  out  1        pulse, cycle after a host read beat
// host_done    out  1        pulse, cycle after final beat
// mem_we       out  1        dram write enable
// mem_addr     out  ADDR_W   dram address
// mem_wdata    out  DATA_W   dram write data
// mem_rdata    in   DATA_W   dram asynchronous read data
// BEHAVIOUR
// States
// - IDLE:  no burst in progress.
// - BURST: burst latched; one beat per granted cycle.
// Control terms
// - host_act = (IDLE & host_req) | BURST.
// - force    = (wait_cnt == MAX_WAIT).
// - host_win = host_act & (~cpu_req | force).
// - host_gnt = host_win; cpu_stall = cpu_req & host_win.
// Per-cycle RAM drive
// - If host_win: mem_* carry the host beat.
//   - Beat address = (IDLE ? host_addr : base + beat_cnt) mod 2^ADDR_W; wrap-around is silent.
// - Else if cpu_req: mem_* carry cpu_*.
// - Else: mem_we = 0, mem_addr = cpu_addr.
// wait_cnt
// - Increments (saturating at MAX_WAIT) when host_act & ~host_win.
// - Clears on any host beat and in IDLE without host_req.
// Transitions
// - IDLE -> BURST on host_act: latch we/addr/len.
//   - If beat 0 is granted in the same cycle, beat_cnt = 1.
//   - If host_len == 0 and beat 0 is granted, stay IDLE and pulse host_done next cycle.
// - BURST -> IDLE after the beat with beat_cnt == len is granted.
// Rules
// - host_req changes mid-burst are ignored; the burst always completes.
// - Latency
//   - Host write beat commits at the granting edge.
//   - Host read: host_rdata/host_rvalid valid one cycle after host_gnt.
// - A CPU store is never partially applied: when stalled, no CPU write reaches dram.
// - At most one forced cycle per MAX_WAIT+1 cycles; CPU worst-case added latency = 1 cycle per beat.
// Reset values (any state, including mid-burst)
// - state = IDLE; wait_cnt, beat_cnt, base, len = 0.
// - host_rdata = 0; host_rvalid = host_done = 0.
// - Remaining beats are abandoned and no further dram writes occur.
// - Combinational outputs follow from these values; the first cycle after reset behaves as IDLE.
// STRUCTURE
// - Package dmem_arb_pkg: state enum {ARB_IDLE, ARB_BURST}, default ADDR_W/DATA_W/BURST_W/MAX_WAIT localparams.
// - One sub-module: arb_starve_cnt (saturating wait counter; outputs force).
// - Datapath mux and FSM stay in the top.
// TESTING
// 1. CPU only: cpu_req=1 every cycle, host idle, 20 cycles -> cpu_stall=0 throughout; mem_* track cpu_*.
// 2. Host write, CPU idle: host_addr=0x3FE, len=3, data A..D
//    -> addresses 0x3FE, 0x3FF, 0x000, 0x001 written (wrap-around);
//    -> host_gnt on 4 consecutive cycles; host_done one cycle later.
// 3. Starvation: cpu_req=1 constantly, host read len=1, MAX_WAIT=8
//    -> first host beat on the 9th cycle with cpu_stall=1 for that cycle only;
//    -> second beat 9 cycles later; host_rvalid follows each beat by 1 cycle.
// 4. Interleave: cpu_req toggles 1/0, host write len=5
//    -> host beats occur only in cpu_req=0 cycles; no cpu_stall; 6 words correct.
// 5. Reset mid-burst: reset during beat 2 of a len=7 write
//    -> next cycle IDLE; outputs zero; words 3..7 unchanged in dram.
// 6. Simultaneous CPU store and forced host write to the same address
//    -> host data written, CPU stalled; CPU store lands the following cycle and its value is final.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizing for the data-RAM port arbiter.
package dmem_arb_pkg;

    localparam int unsigned DEF_ADDR_W   = 10;
    localparam int unsigned DEF_DATA_W   = 32;
    localparam int unsigned DEF_BURST_W  = 4;
    localparam int unsigned DEF_MAX_WAIT = 8;

    // IDLE: no burst latched; BURST: burst latched, one beat per granted cycle
    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_e;

    // Width of a counter that must hold values 0..max_val
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of CPU, host-loader and dram signals around the data-RAM arbiter.
interface dmem_port_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned BURST_W = DEF_BURST_W
);

    // CPU load/store path
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    // Host/debug loader
    logic               host_req;
    logic               host_we;
    logic [ADDR_W-1:0]  host_addr;
    logic [BURST_W-1:0] host_len;
    logic [DATA_W-1:0]  host_wdata;
    logic               host_gnt;
    logic [DATA_W-1:0]  host_rdata;
    logic               host_rvalid;
    logic               host_done;

    // Single-port dram
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  host_req, host_we, host_addr, host_len, host_wdata,
        output host_gnt, host_rdata, host_rvalid, host_done,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Environment side (core, loader and dram together)
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output host_req, host_we, host_addr, host_len, host_wdata,
        input  host_gnt, host_rdata, host_rvalid, host_done,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/arb_starve_cnt.sv
// Counts consecutive cycles the host was denied; flags when it must be forced through.
module arb_starve_cnt
    import dmem_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic clock,
    input  logic reset,
    input  logic host_act,
    input  logic host_win,
    output logic force_beat_c
);

    localparam int unsigned CNT_W = cnt_width(MAX_WAIT);

    logic [CNT_W-1:0] wait_q;

    // Saturating denied-cycle counter; any host beat or an absent host clears it
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_q <= '0;
        end else if (host_win || !host_act) begin
            wait_q <= '0;
        end else if (wait_q != CNT_W'(MAX_WAIT)) begin
            wait_q <= wait_q + CNT_W'(1);
        end
    end

    // Host has waited long enough to take the port from the CPU
    assign force_beat_c = (wait_q == CNT_W'(MAX_WAIT));

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data RAM between the CPU and a host burst loader.
// CPU wins by default; a starved host gets one forced beat, stalling the CPU.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned BURST_W  = DEF_BURST_W,
    parameter int unsigned MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic clock,
    input  logic reset,
    dmem_port_arbiter_if.slave bus
);

    arb_state_e         state_q, state_d;
    logic [BURST_W-1:0] beat_q, beat_d;
    logic [BURST_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic               we_q, we_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               rvalid_q, rvalid_d;
    logic               done_q, done_d;

    logic               host_act;
    logic               host_win;
    logic               force_beat_c;
    logic               cur_we;
    logic [BURST_W-1:0] cur_len;
    logic [BURST_W-1:0] cur_idx;
    logic               last_beat;
    logic [ADDR_W-1:0]  beat_addr;

    logic               mem_we_c;
    logic [ADDR_W-1:0]  mem_addr_c;
    logic [DATA_W-1:0]  mem_wdata_c;

    arb_starve_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clock        (clock),
        .reset        (reset),
        .host_act     (host_act),
        .host_win     (host_win),
        .force_beat_c (force_beat_c)
    );

    // Current host beat: taken live from the ports in IDLE, from the latched burst otherwise
    always_comb begin
        host_act  = 1'b1;
        cur_we    = we_q;
        cur_len   = len_q;
        cur_idx   = beat_q;
        beat_addr = base_q + ADDR_W'(beat_q);
        if (state_q == ARB_IDLE) begin
            host_act  = bus.host_req;
            cur_we    = bus.host_we;
            cur_len   = bus.host_len;
            cur_idx   = '0;
            beat_addr = bus.host_addr;
        end
        host_win  = host_act && (!bus.cpu_req || force_beat_c);
        last_beat = (cur_idx == cur_len);
    end

    // Burst FSM next state plus registered host read/done responses
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        len_d    = len_q;
        base_d   = base_q;
        we_d     = we_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (bus.host_req) begin
                    we_d    = bus.host_we;
                    base_d  = bus.host_addr;
                    len_d   = bus.host_len;
                    beat_d  = '0;
                    state_d = ARB_BURST;
                    if (host_win) begin
                        if (last_beat) begin
                            // Single-beat burst finished on acceptance
                            state_d = ARB_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            beat_d = BURST_W'(1);
                        end
                    end
                end
            end
            ARB_BURST: begin
                if (host_win) begin
                    if (last_beat) begin
                        state_d = ARB_IDLE;
                        beat_d  = '0;
                        done_d  = 1'b1;
                    end else begin
                        beat_d = beat_q + BURST_W'(1);
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        if (host_win && !cur_we) begin
            rvalid_d = 1'b1;
            rdata_d  = bus.mem_rdata;
        end
    end

    // State and response registers; reset abandons any burst in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ARB_IDLE;
            beat_q   <= '0;
            len_q    <= '0;
            base_q   <= '0;
            we_q     <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            len_q    <= len_d;
            base_q   <= base_d;
            we_q     <= we_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            done_q   <= done_d;
        end
    end

    // dram port mux; writes are blocked while reset is held so no abandoned beat lands
    always_comb begin
        mem_we_c    = 1'b0;
        mem_addr_c  = bus.cpu_addr;
        mem_wdata_c = bus.cpu_wdata;
        if (host_win) begin
            mem_we_c    = cur_we;
            mem_addr_c  = beat_addr;
            mem_wdata_c = bus.host_wdata;
        end else if (bus.cpu_req) begin
            mem_we_c    = bus.cpu_we;
            mem_addr_c  = bus.cpu_addr;
            mem_wdata_c = bus.cpu_wdata;
        end
        mem_we_c = mem_we_c && !reset;
    end

    assign bus.mem_we      = mem_we_c;
    assign bus.mem_addr    = mem_addr_c;
    assign bus.mem_wdata   = mem_wdata_c;
    assign bus.cpu_rdata   = bus.mem_rdata;
    assign bus.cpu_stall   = bus.cpu_req && host_win;
    assign bus.host_gnt    = host_win;
    assign bus.host_rdata  = rdata_q;
    assign bus.host_rvalid = rvalid_q;
    assign bus.host_done   = done_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: a transaction-level model predicts every
// cycle's port drive and the registered host responses; a negedge monitor checks them.
module tb_dmem_port_arbiter;
    import dmem_arb_pkg::*;

    localparam int unsigned AW    = DEF_ADDR_W;
    localparam int unsigned DW    = DEF_DATA_W;
    localparam int unsigned BW    = DEF_BURST_W;
    localparam int unsigned MW    = DEF_MAX_WAIT;
    localparam int unsigned DEPTH = 1 << AW;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    dmem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .BURST_W(BW)) bus ();

    dmem_port_arbiter #(
        .ADDR_W (AW), .DATA_W (DW), .BURST_W (BW), .MAX_WAIT (MW)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [DW-1:0] init_val(input int i);
        return DW'(32'hC0DE_0000 + i);
    endfunction

    // dram model: asynchronous read, write on rising edge, preloaded at first edge
    logic [DW-1:0] ram [DEPTH];
    logic          ram_ready = 1'b0;
    assign bus.mem_rdata = ram[bus.mem_addr];
    always @(posedge clock) begin
        if (!ram_ready) begin
            for (int i = 0; i < int'(DEPTH); i++) ram[i] <= init_val(i);
            ram_ready <= 1'b1;
        end else if (bus.mem_we) begin
            ram[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } due_t;

    typedef struct {
        logic          rst;
        logic          post_rst;
        logic          gnt;
        logic          stall;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          rchk;
        logic [DW-1:0] rdata;
    } exp_t;

    logic [DW-1:0] model_mem [DEPTH];
    beat_t host_q [$];
    due_t  rd_q [$];
    int    done_q [$];
    exp_t  cyc_q [$];
    int    gnt_seen [$];

    int   n_checks = 0;
    int   n_err    = 0;
    int   starve   = 0;
    logic hold     = 1'b0;
    logic prev_rst = 1'b0;

    logic          hp_pend = 1'b0;
    logic          hp_we;
    logic [AW-1:0] hp_addr;
    logic [BW-1:0] hp_len;
    logic [DW-1:0] hp_d0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compare each cycle's combinational drive and the registered responses
    always @(negedge clock) begin
        exp_t e;
        due_t r;
        if (bus.host_gnt === 1'b1) gnt_seen.push_back(cyc);
        if (cyc_q.size() != 0) begin
            e = cyc_q.pop_front();
            if (e.rst) begin
                chk("mem_we_in_reset", DW'(bus.mem_we), DW'(1'b0));
            end else begin
                chk("host_gnt",  DW'(bus.host_gnt),  DW'(e.gnt));
                chk("cpu_stall", DW'(bus.cpu_stall), DW'(e.stall));
                chk("mem_we",    DW'(bus.mem_we),    DW'(e.we));
                chk("mem_addr",  DW'(bus.mem_addr),  DW'(e.addr));
                if (e.we)   chk("mem_wdata", bus.mem_wdata, e.wdata);
                if (e.rchk) chk("cpu_rdata", bus.cpu_rdata, e.rdata);
                if (e.post_rst) chk("host_rdata_after_reset", bus.host_rdata, DW'(0));
            end
            if (rd_q.size() != 0 && rd_q[0].due == cyc) begin
                r = rd_q.pop_front();
                chk("host_rvalid", DW'(bus.host_rvalid), DW'(1'b1));
                chk("host_rdata",  bus.host_rdata, r.data);
            end else begin
                chk("host_rvalid_quiet", DW'(bus.host_rvalid), DW'(1'b0));
            end
            if (done_q.size() != 0 && done_q[0] == cyc) begin
                void'(done_q.pop_front());
                chk("host_done", DW'(bus.host_done), DW'(1'b1));
            end else begin
                chk("host_done_quiet", DW'(bus.host_done), DW'(1'b0));
            end
        end
    end

    task automatic req_burst(input logic we, input logic [AW-1:0] a,
                             input logic [BW-1:0] len, input logic [DW-1:0] d0);
        hp_pend = 1'b1;
        hp_we   = we;
        hp_addr = a;
        hp_len  = len;
        hp_d0   = d0;
    endtask

    // One clock of stimulus; the reference model decides who owns the RAM this cycle
    task automatic step(input logic rq, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic rst);
        exp_t          e;
        beat_t         b;
        due_t          r;
        logic          active;
        logic          win;
        @(posedge clock);
        #1;
        if (!hold) begin
            bus.cpu_req   = rq;
            bus.cpu_we    = we;
            bus.cpu_addr  = a;
            bus.cpu_wdata = d;
        end
        reset      = rst;
        e          = '{default: '0};
        e.post_rst = prev_rst && !rst;
        prev_rst   = rst;
        if (rst) begin
            host_q.delete();
            starve       = 0;
            hold         = 1'b0;
            bus.host_req = 1'b0;
            e.rst        = 1'b1;
            cyc_q.push_back(e);
            return;
        end
        if (host_q.size() == 0 && hp_pend) begin
            bus.host_req  = 1'b1;
            bus.host_we   = hp_we;
            bus.host_addr = hp_addr;
            bus.host_len  = hp_len;
            for (int i = 0; i <= int'(hp_len); i++) begin
                b.addr = hp_addr + AW'(i);
                b.we   = hp_we;
                b.data = hp_d0 + DW'(i);
                b.last = (i == int'(hp_len));
                host_q.push_back(b);
            end
            hp_pend = 1'b0;
        end else begin
            // Mid-burst request fields are junk and must be ignored
            bus.host_req  = (host_q.size() != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.host_we   = 1'($urandom_range(0, 1));
            bus.host_addr = AW'($urandom);
            bus.host_len  = BW'($urandom);
        end
        bus.host_wdata = (host_q.size() != 0) ? host_q[0].data : DW'($urandom);

        active  = (host_q.size() != 0);
        win     = active && (!bus.cpu_req || starve == int'(MW));
        e.gnt   = win;
        e.stall = bus.cpu_req && win;
        if (win) begin
            b       = host_q.pop_front();
            e.we    = b.we;
            e.addr  = b.addr;
            e.wdata = b.data;
            if (b.we) begin
                model_mem[b.addr] = b.data;
            end else begin
                r.data = model_mem[b.addr];
                r.due  = cyc + 1;
                rd_q.push_back(r);
            end
            if (b.last) done_q.push_back(cyc + 1);
            starve = 0;
        end else begin
            e.we    = bus.cpu_req && bus.cpu_we;
            e.addr  = bus.cpu_addr;
            e.wdata = bus.cpu_wdata;
            e.rchk  = bus.cpu_req && !bus.cpu_we;
            e.rdata = model_mem[bus.cpu_addr];
            if (bus.cpu_req && bus.cpu_we) model_mem[bus.cpu_addr] = bus.cpu_wdata;
            starve = active ? starve + 1 : 0;
        end
        hold = e.stall;
        cyc_q.push_back(e);
    endtask

    initial begin
        int t0;
        int guard;
        int bad;
        logic [AW-1:0] a;

        for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = init_val(i);
        reset          = 1'b1;
        bus.cpu_req    = 1'b0;
        bus.cpu_we     = 1'b0;
        bus.cpu_addr   = '0;
        bus.cpu_wdata  = '0;
        bus.host_req   = 1'b0;
        bus.host_we    = 1'b0;
        bus.host_addr  = '0;
        bus.host_len   = '0;
        bus.host_wdata = '0;
        step(1'b0, 1'b0, '0, '0, 1'b1);
        step(1'b0, 1'b0, '0, '0, 1'b1);

        // CPU only
        for (int i = 0; i < 20; i++)
            step(1'b1, 1'($urandom_range(0, 1)), AW'(10'h300 + $urandom_range(0, 63)), DW'($urandom), 1'b0);

        // Host write with address wrap, CPU idle
        req_burst(1'b1, AW'(10'h3FE), BW'(3), DW'(32'hA));
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, '0, 1'b0);
        chk("wrap_word0", ram[10'h3FE], DW'(32'hA));
        chk("wrap_word1", ram[10'h3FF], DW'(32'hB));
        chk("wrap_word2", ram[10'h000], DW'(32'hC));
        chk("wrap_word3", ram[10'h001], DW'(32'hD));

        // Starvation: CPU loads every cycle, host read of two beats
        gnt_seen.delete();
        t0 = cyc + 1;
        req_burst(1'b0, AW'(10'h100), BW'(1), '0);
        for (int i = 0; i < 22; i++) step(1'b1, 1'b0, AW'($urandom_range(0, 1023)), '0, 1'b0);
        @(negedge clock);
        #1;
        chk("starve_gnt_count", DW'(gnt_seen.size()), DW'(2));
        if (gnt_seen.size() >= 2) begin
            chk("starve_first_beat_cycle",  DW'(gnt_seen[0]), DW'(t0 + 8));
            chk("starve_second_beat_cycle", DW'(gnt_seen[1]), DW'(t0 + 17));
        end

        // Interleave: host beats only in CPU-idle cycles
        req_burst(1'b1, AW'(10'h040), BW'(5), DW'(32'h400));
        for (int i = 0; i < 16; i++)
            step(1'((i % 2) == 0), 1'b1, AW'(10'h200 + i), DW'(32'h7700 + i), 1'b0);
        for (int i = 0; i < 6; i++) chk("interleave_word", ram[10'h040 + i], DW'(32'h400 + i));

        // Reset in the middle of a long write burst
        req_burst(1'b1, AW'(10'h080), BW'(7), DW'(32'h500));
        step(1'b0, 1'b0, '0, '0, 1'b0);
        step(1'b0, 1'b0, '0, '0, 1'b0);
        step(1'b0, 1'b0, '0, '0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0, '0, 1'b0);
        chk("abandon_word0", ram[10'h080], DW'(32'h500));
        chk("abandon_word1", ram[10'h081], DW'(32'h501));
        for (int i = 3; i < 8; i++) chk("abandon_untouched", ram[10'h080 + i], init_val(10'h080 + i));

        // Forced host write collides with a CPU store to the same word
        req_burst(1'b1, AW'(10'h0C0), BW'(0), DW'(32'hB0B));
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, AW'(10'h0C0), DW'(32'h600D), 1'b0);
        step(1'b0, 1'b0, '0, '0, 1'b0);
        chk("collision_cpu_final", ram[10'h0C0], DW'(32'h600D));

        // Randomized traffic concentrated around the top of the address space
        for (int i = 0; i < 1500; i++) begin
            if (!hp_pend && host_q.size() == 0 && $urandom_range(0, 3) == 0) begin
                a = AW'(10'h3F0 + $urandom_range(0, 31));
                req_burst(1'($urandom_range(0, 1)), a, BW'($urandom), DW'($urandom));
            end
            step(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)),
                 AW'(10'h3F0 + $urandom_range(0, 31)), DW'($urandom),
                 1'($urandom_range(0, 399) == 0));
        end

        // Drain any outstanding burst with the CPU quiet
        guard = 0;
        while ((host_q.size() != 0 || hp_pend) && guard < 100) begin
            step(1'b0, 1'b0, '0, '0, 1'b0);
            guard++;
        end
        chk("drain_complete", DW'(host_q.size()), DW'(0));
        step(1'b0, 1'b0, '0, '0, 1'b0);
        step(1'b0, 1'b0, '0, '0, 1'b0);
        @(negedge clock);
        #1;
        chk("pending_reads", DW'(rd_q.size()), DW'(0));
        chk("pending_dones", DW'(done_q.size()), DW'(0));

        bad = 0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (ram[i] !== model_mem[i]) begin
                if (bad < 4) $display("ram word %0h differs: dram=%h model=%h", i, ram[i], model_mem[i]);
                bad++;
            end
        end
        chk("ram_image_bad_words", DW'(bad), DW'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
